reg_file16: RTL and testbench
=============================

REG_FILE16 -- requirements
Module: reg_file16

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width in bits of every register and data port.
REQ-002 Parameter NREGS, default 16, SHALL set the number of architectural registers; address width = log2(NREGS) = 4.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 RegWrite  input  1  SHALL be the write enable.
REQ-006 WriteAddr  input  4  SHALL be the destination register index.
REQ-007 WriteData  input  WIDTH  SHALL be the value to write.
REQ-008 ReadAddrA  input  4  SHALL be the read port A register index.
REQ-009 ReadAddrB  input  4  SHALL be the read port B register index.
REQ-010 ReadDataA  output  WIDTH  SHALL carry read port A data, driving operand input A of the downstream 2-input 16-bit select mux.
REQ-011 ReadDataB  output  WIDTH  SHALL carry read port B data, driving operand input B of the same mux.

Function
REQ-012 The block SHALL hold NREGS registers of WIDTH bits, r0..r15.
REQ-013 r0 SHALL read as 0x0000 at all times; writes to index 0 SHALL be discarded.
REQ-014 Write: on a rising CLK edge with Reset=0, RegWrite=1 and WriteAddr!=0, r[WriteAddr] SHALL take WriteData; all other registers SHALL hold.
REQ-015 RegWrite=0 SHALL leave every register unchanged regardless of WriteAddr/WriteData.
REQ-016 Reads SHALL be combinational, zero latency: ReadDataX = r[ReadAddrX] within the same cycle.
REQ-017 Bypass: when RegWrite=1, WriteAddr!=0, WriteAddr==ReadAddrX and Reset=0, ReadDataX SHALL equal WriteData combinationally in that same cycle (write-before-read).
REQ-018 Bypass SHALL apply independently to both ports; both ports addressing the write target SHALL both return WriteData.
REQ-019 Bypass SHALL NOT apply for index 0; the port SHALL return 0x0000.
REQ-020 Both ports addressing the same register SHALL return identical data.
REQ-021 A value written at edge N SHALL be visible on a non-bypassed read from cycle N+1 onward and persist until overwritten or reset.

Reset
REQ-022 Reset=1 at a rising CLK edge SHALL clear r1..r15 to 0x0000.
REQ-023 Reset SHALL have priority over a simultaneous write; the write SHALL be discarded.
REQ-024 While Reset=1, bypass SHALL be suppressed; reads SHALL return stored contents (0x0000 after the first reset edge).
REQ-025 Reset asserted mid-sequence SHALL discard all prior writes; registers written only after Reset deasserts SHALL hold data.
REQ-026 Register contents before the first reset edge are undefined; no read is checked before reset.

Structure
REQ-027 WIDTH, NREGS, address width and the constant ZERO_REG=0 SHALL reside in a shared datapath package used by the mux and other datapath stages.
REQ-028 One sub-module, reg16 (WIDTH-bit register with synchronous active-high reset and load enable), SHALL be instantiated once per register r1..r15.
REQ-029 Write-address decode, read selection and bypass logic SHALL be in reg_file16 itself; no latches.

Verification
REQ-030 Reset, then read all indices on both ports -> every read returns 0x0000.
REQ-031 Write 0x1234 to r3 at edge N; cycle N+1 ReadAddrA=3, ReadAddrB=3 -> both 0x1234; a mux behind the ports returns 0x1234 for either select.
REQ-032 RegWrite=1, WriteAddr=0, WriteData=0xFFFF; next cycle read r0 -> 0x0000; same-cycle read r0 -> 0x0000 (no bypass).
REQ-033 r5 holds 0x00AA; same cycle RegWrite=1, WriteAddr=5, WriteData=0xBEEF, ReadAddrA=5 -> ReadDataA=0xBEEF before the edge, r5=0xBEEF after.
REQ-034 Write 0x5555 to r7, then Reset=1 with simultaneous write 0x7777 to r7 -> r7 reads 0x0000 after the edge.
REQ-035 Write r(i)=i*0x0101 for i=1..15, then sweep ReadAddrA=i, ReadAddrB=15-i -> each port returns its expected value; RegWrite=0 with varying WriteAddr/WriteData changes nothing.

Source files
------------

// File: rtl/reg_file16_pkg.sv
// Shared datapath constants for the register file and its consumers.
// Imported by the read/write logic and any stage that needs register indices.
package reg_file16_pkg;

   localparam int DP_WIDTH = 16;
   localparam int DP_NREGS = 16;
   localparam int DP_AW    = $clog2(DP_NREGS);

   localparam logic [DP_AW-1:0] ZERO_REG = '0;

   // True when a port should see the in-flight write instead of storage.
   function automatic logic bypass_hit(
      input logic             rst,
      input logic             we,
      input logic [DP_AW-1:0] waddr,
      input logic [DP_AW-1:0] raddr
   );
      return !rst && we && (waddr != ZERO_REG) && (waddr == raddr);
   endfunction

endpackage

// File: rtl/reg_file16_reg16.sv
// Single WIDTH-bit storage register with synchronous
// active-high clear and a load enable.
module reg16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   // Clear wins over load.
   always_comb begin
      data_d = data_q;
      if (rst) begin
         data_d = '0;
      end else if (ld) begin
         data_d = d;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign q = data_q;

endmodule

// File: rtl/reg_file16.sv
// Two-read, one-write register file with a hard-wired zero register
// and same-cycle write-to-read bypass on both ports.
module reg_file16
   import reg_file16_pkg::*;
#(
   parameter int WIDTH = DP_WIDTH,
   parameter int NREGS = DP_NREGS
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             RegWrite,
   input  logic [DP_AW-1:0] WriteAddr,
   input  logic [WIDTH-1:0] WriteData,
   input  logic [DP_AW-1:0] ReadAddrA,
   input  logic [DP_AW-1:0] ReadAddrB,
   output logic [WIDTH-1:0] ReadDataA,
   output logic [WIDTH-1:0] ReadDataB
);

   logic [WIDTH-1:0] rf [NREGS];
   logic [NREGS-1:1] ld;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;

   always_comb begin
      ld = '0;
      for (int i = 1; i < NREGS; i++) begin
         ld[i] = RegWrite && (WriteAddr == DP_AW'(i));
      end
   end

   for (genvar i = 0; i < NREGS; i++) begin : g_regs
      if (i == int'(ZERO_REG)) begin : g_zero
         assign rf[i] = '0;
      end else begin : g_reg
         reg16 #(
            .WIDTH(WIDTH)
         ) u_reg (
            .clk (CLK),
            .rst (Reset),
            .ld  (ld[i]),
            .d   (WriteData),
            .q   (rf[i])
         );
      end
   end

   always_comb begin
      rd_a = rf[ReadAddrA];
      rd_b = rf[ReadAddrB];
      if (bypass_hit(Reset, RegWrite, WriteAddr, ReadAddrA)) begin
         rd_a = WriteData;
      end
      if (bypass_hit(Reset, RegWrite, WriteAddr, ReadAddrB)) begin
         rd_b = WriteData;
      end
   end

   assign ReadDataA = rd_a;
   assign ReadDataB = rd_b;

endmodule

// File: tb/tb_reg_file16.sv
// Randomised and directed scoreboard bench for the register file.
module tb_reg_file16;

   logic        CLK;
   logic        Reset;
   logic        RegWrite;
   logic [3:0]  WriteAddr;
   logic [15:0] WriteData;
   logic [3:0]  ReadAddrA;
   logic [3:0]  ReadAddrB;
   logic [15:0] ReadDataA;
   logic [15:0] ReadDataB;

   reg_file16 #(
      .WIDTH(16),
      .NREGS(16)
   ) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .RegWrite  (RegWrite),
      .WriteAddr (WriteAddr),
      .WriteData (WriteData),
      .ReadAddrA (ReadAddrA),
      .ReadAddrB (ReadAddrB),
      .ReadDataA (ReadDataA),
      .ReadDataB (ReadDataB)
   );

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
   } exp_t;

   exp_t        exp_q[$];
   string       name_q[$];
   logic [15:0] mem [16];
   bit          model_ok;
   int          tests;
   int          fails;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [15:0] ref_rd(
      input logic [3:0]  a,
      input bit          rst,
      input bit          we,
      input logic [3:0]  wa,
      input logic [15:0] wd
   );
      if (a == 4'd0) return 16'h0000;
      if (!rst && we && wa == a) return wd;
      return mem[a];
   endfunction

   task automatic step(
      input bit          rst,
      input bit          we,
      input logic [3:0]  wa,
      input logic [15:0] wd,
      input logic [3:0]  ra,
      input logic [3:0]  rb,
      input string       nm
   );
      exp_t e;
      @(posedge CLK);
      #1;
      Reset     = rst;
      RegWrite  = we;
      WriteAddr = wa;
      WriteData = wd;
      ReadAddrA = ra;
      ReadAddrB = rb;
      if (model_ok) begin
         e.a = ref_rd(ra, rst, we, wa, wd);
         e.b = ref_rd(rb, rst, we, wa, wd);
         exp_q.push_back(e);
         name_q.push_back(nm);
      end
      if (rst) begin
         for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
         model_ok = 1'b1;
      end else if (we && wa != 4'd0) begin
         mem[wa] = wd;
      end
   endtask

   always @(negedge CLK) begin
      exp_t  e;
      string nm;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         tests++;
         if (ReadDataA !== e.a) begin
            fails++;
            $display("FAIL %s portA ra=%0d got %h want %h",
                     nm, ReadAddrA, ReadDataA, e.a);
         end
         tests++;
         if (ReadDataB !== e.b) begin
            fails++;
            $display("FAIL %s portB rb=%0d got %h want %h",
                     nm, ReadAddrB, ReadDataB, e.b);
         end
      end
   end

   initial begin
      logic [3:0]  wa;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [15:0] wd;
      bit          rst;
      bit          we;
      tests     = 0;
      fails     = 0;
      model_ok  = 1'b0;
      Reset     = 1'b1;
      RegWrite  = 1'b0;
      WriteAddr = '0;
      WriteData = '0;
      ReadAddrA = '0;
      ReadAddrB = '0;

      step(1, 0, 0, 0, 0, 0, "pre_reset");
      step(1, 1, 4'd4, 16'hABCD, 4'd4, 4'd1, "in_reset");

      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, 0, 4'(i), 4'(15 - i), "reset_sweep");
      end

      step(0, 1, 4'd3, 16'h1234, 4'd0, 4'd1, "wr_r3");
      step(0, 0, 0, 0, 4'd3, 4'd3, "rd_r3");

      step(0, 1, 4'd0, 16'hFFFF, 4'd0, 4'd0, "r0_same_cycle");
      step(0, 0, 0, 0, 4'd0, 4'd0, "r0_next");

      step(0, 1, 4'd5, 16'h00AA, 4'd2, 4'd2, "wr_r5");
      step(0, 1, 4'd5, 16'hBEEF, 4'd5, 4'd6, "byp_r5");
      step(0, 0, 0, 0, 4'd5, 4'd5, "rd_r5");

      step(0, 1, 4'd9, 16'hC0DE, 4'd9, 4'd9, "byp_both");

      step(0, 1, 4'd7, 16'h5555, 4'd7, 4'd0, "wr_r7");
      step(0, 0, 0, 0, 4'd7, 4'd7, "rd_r7");
      step(1, 1, 4'd7, 16'h7777, 4'd7, 4'd7, "rst_vs_wr");
      step(0, 0, 0, 0, 4'd7, 4'd9, "after_rst");

      for (int i = 1; i < 16; i++) begin
         step(0, 1, 4'(i), 16'(i * 16'h0101), 4'(i), 4'(16 - i), "fill");
      end
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, 0, 4'(i), 4'(15 - i), "fill_sweep");
      end
      for (int i = 0; i < 16; i++) begin
         wa = 4'($urandom_range(0, 15));
         wd = 16'($urandom);
         step(0, 0, wa, wd, 4'(i), wa, "we_off");
      end
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, 0, 4'(i), 4'(15 - i), "hold_sweep");
      end

      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 24) == 0);
         we  = $urandom_range(0, 1) == 1;
         wa  = 4'($urandom_range(0, 15));
         wd  = 16'($urandom);
         ra  = 4'($urandom_range(0, 15));
         rb  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) ra = wa;
         if ($urandom_range(0, 3) == 0) rb = wa;
         step(rst, we, wa, wd, ra, rb, "rand");
      end

      repeat (3) @(negedge CLK);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain left %0d want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
